// File: rtl/correlating_predictor_pkg.sv
// Shared definitions for the correlating branch predictor: counter encodings,
// reset value and the saturating up/down step.
package correlating_predictor_pkg;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // A 1-bit counter has no "weak" state, so it resets to not-taken.
  function automatic int unsigned ctr_reset_val(input int unsigned ctr_w);
    return (ctr_w == 1) ? 32'd0 : 32'(CTR_WNT);
  endfunction

  function automatic int unsigned sat_next(input int unsigned cur,
                                           input int unsigned max_val,
                                           input logic up);
    if (up) return (cur >= max_val) ? cur : cur + 1;
    return (cur == 0) ? cur : cur - 1;
  endfunction

endpackage

// File: rtl/correlating_predictor_sat_counter.sv
// CTR_W-bit up/down saturating counter, one per prediction table entry.
module sat_counter
  import correlating_predictor_pkg::*;
#(
  parameter int CTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  output logic [CTR_W-1:0] count
);

  localparam int unsigned      MAX_VAL = (1 << CTR_W) - 1;
  localparam logic [CTR_W-1:0] RST_VAL = CTR_W'(ctr_reset_val(CTR_W));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count <= RST_VAL;
    else if (en) count <= CTR_W'(sat_next(32'(count), MAX_VAL, up));
  end

endmodule

// File: rtl/correlating_predictor.sv
// (m,n) correlating branch predictor: global history plus a table of
// saturating counters indexed by {ghr, branch_address}.
// Optional statistics counters: define CORRELATING_PREDICTOR_STATS_EN.
module correlating_predictor
  import correlating_predictor_pkg::*;
#(
  parameter int ADDR_W = 1,
  parameter int HIST_W = 2,
  parameter int CTR_W  = 2,
  parameter int STAT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [ADDR_W-1:0] branch_address,
  input  logic              branch_result,
`ifdef CORRELATING_PREDICTOR_STATS_EN
  output logic [STAT_W-1:0] hit_count,
  output logic [STAT_W-1:0] miss_count,
`endif
  output logic              prediction
);

  localparam int IDX_W   = HIST_W + ADDR_W;
  localparam int ENTRIES = 1 << IDX_W;

  logic [HIST_W-1:0] ghr;
  logic [IDX_W-1:0]  idx;
  logic [CTR_W-1:0]  ctr [ENTRIES];
  logic              cur_pred;

  assign idx      = {ghr, branch_address};
  assign cur_pred = ctr[idx][CTR_W-1];

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_tbl
    sat_counter #(.CTR_W(CTR_W)) u_ctr (
      .clk   (clk),
      .rst   (rst),
      .en    (enable && (idx == IDX_W'(gi))),
      .up    (branch_result),
      .count (ctr[gi])
    );
  end

  // Truncating {ghr, result} keeps the newest HIST_W outcomes, also for HIST_W=1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ghr        <= '0;
      prediction <= 1'b0;
    end else if (enable) begin
      ghr        <= HIST_W'({ghr, branch_result});
      prediction <= cur_pred;
    end
  end

`ifdef CORRELATING_PREDICTOR_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (enable) begin
      if (cur_pred == branch_result) hit_count  <= hit_count + STAT_W'(1);
      else                           miss_count <= miss_count + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_correlating_predictor.sv
// Self-checking bench for correlating_predictor against a behavioural model.
module tb_correlating_predictor;

  localparam int ADDR_W = 1;
  localparam int HIST_W = 2;
  localparam int CTR_W  = 2;
  localparam int STAT_W = 32;
  localparam int NE     = 1 << (HIST_W + ADDR_W);
  localparam int CMAX   = (1 << CTR_W) - 1;
  localparam int CRST   = (CTR_W == 1) ? 0 : 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              enable = 1'b0;
  logic [ADDR_W-1:0] branch_address = '0;
  logic              branch_result = 1'b0;
  logic              prediction;
`ifdef CORRELATING_PREDICTOR_STATS_EN
  logic [STAT_W-1:0] hit_count, miss_count;
`endif

  correlating_predictor #(.ADDR_W(ADDR_W), .HIST_W(HIST_W), .CTR_W(CTR_W), .STAT_W(STAT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .branch_address (branch_address),
    .branch_result  (branch_result),
`ifdef CORRELATING_PREDICTOR_STATS_EN
    .hit_count      (hit_count),
    .miss_count     (miss_count),
`endif
    .prediction     (prediction)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  int          tbl [NE];
  int          m_ghr;
  int          m_pred;
  longint      m_hit, m_miss;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NE; i++) tbl[i] = CRST;
    m_ghr  = 0;
    m_pred = 0;
    m_hit  = 0;
    m_miss = 0;
  endfunction

  // One enabled branch: model predicts from pre-update state, then trains.
  task automatic step(input int addr, input int res);
    int idx;
    @(negedge clk);
    enable         = 1'b1;
    branch_address = ADDR_W'(addr);
    branch_result  = res[0];
    idx    = m_ghr * (1 << ADDR_W) + addr;
    m_pred = tbl[idx] >> (CTR_W - 1);
    if (m_pred == res) m_hit++; else m_miss++;
    if (res != 0) tbl[idx] = (tbl[idx] < CMAX) ? tbl[idx] + 1 : CMAX;
    else          tbl[idx] = (tbl[idx] > 0) ? tbl[idx] - 1 : 0;
    m_ghr = (m_ghr * 2 + res) % (1 << HIST_W);
    @(posedge clk);
    #1;
    chk("pred", {63'd0, prediction}, 64'(m_pred));
    chk("ghr", 64'(dut.ghr), 64'(m_ghr));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    model_reset();
    chk("rst_pred", {63'd0, prediction}, 64'd0);
    chk("rst_ghr", 64'(dut.ghr), 64'd0);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int held;
    int warm_exp [4] = '{0, 0, 0, 1};
    int warm_ghr [4] = '{1, 3, 3, 3};
    int corr_miss;
    int loop_exp;

    model_reset();
    #12;
    chk("por_pred", {63'd0, prediction}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Warm-up: address 0 always taken
    for (int i = 0; i < 4; i++) begin
      step(0, 1);
      chk("warm_pred", {63'd0, prediction}, 64'(warm_exp[i]));
      chk("warm_ghr", 64'(dut.ghr), 64'(warm_ghr[i]));
    end
    chk("warm_ctr6", 64'(dut.ctr[6]), 64'd3);

    // Saturation at index {11,0}, then a not-taken, then back to the same index
    for (int i = 0; i < 3; i++) step(0, 1);
    step(0, 0);
    chk("sat_miss_pred", {63'd0, prediction}, 64'd1);
    step(1, 1);
    step(1, 1);
    step(0, 1);
    chk("sat_after_pred", {63'd0, prediction}, 64'd1);

    // Random traffic
    for (int i = 0; i < 100; i++) step(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));

    // Enable gating
    @(negedge clk);
    enable = 1'b0;
    held = int'(prediction);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      branch_address = ADDR_W'($urandom_range(0, 1));
      branch_result  = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      chk("gate_pred", {63'd0, prediction}, 64'(held));
      chk("gate_ghr", 64'(dut.ghr), 64'(m_ghr));
    end
    for (int i = 0; i < NE; i++) chk("gate_tbl", 64'(dut.ctr[i]), 64'(tbl[i]));
    for (int i = 0; i < 50; i++) step(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));

    // Mid-run asynchronous reset
    do_reset();
    step(int'($urandom_range(0, 1)), 1);
    chk("post_rst_pred", {63'd0, prediction}, 64'd0);

    // Correlation: address 1 alternating T,N
    do_reset();
    corr_miss = 0;
    for (int i = 0; i < 40; i++) begin
      step(1, (i % 2 == 0) ? 1 : 0);
      if (i >= 8 && int'(prediction) != ((i % 2 == 0) ? 1 : 0)) corr_miss++;
    end
    chk("corr_miss", 64'(corr_miss), 64'd0);
    chk("corr_ctr10", 64'(dut.ctr[5] >> (CTR_W - 1)), 64'd1);
    chk("corr_ctr01", 64'(dut.ctr[3] >> (CTR_W - 1)), 64'd0);

    // Long loop
    do_reset();
    for (int it = 0; it < 40; it++) begin
      step(0, 1);
      for (int j = 0; j < 1000; j++) step(1, 1);
      step(1, 0);
    end
    step(0, 0);
    chk("loop_total", 64'(m_hit + m_miss), 64'd40081);
    loop_exp = (m_miss <= 50) ? 1 : 0;
    chk("loop_miss_bound", 64'(loop_exp), 64'd1);
`ifdef CORRELATING_PREDICTOR_STATS_EN
    chk("loop_hits", 64'(hit_count), 64'(m_hit));
    chk("loop_misses", 64'(miss_count), 64'(m_miss));
    chk("loop_sum", 64'(hit_count) + 64'(miss_count), 64'd40081);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
